multi_bit_serial_compare: RTL and testbench

Sequential, parametrised magnitude comparator that compares two WIDTH-bit operands CHUNK bits per clock, most-significant chunk first, and exits early as soon as a chunk differs. It is the multi-bit successor of the single-bit cascade compare cell. It adds a signed mode and a start/done handshake, and it keeps the lin/gin priority-override inputs so it can still sit in a comparator cascade. It serves datapaths that need wide compares without a wide combinational compare tree.

---
 rtl/comparator_pkg.sv | 18 +
 rtl/chunk_compare.sv | 28 ++
 rtl/multi_bit_serial_compare.sv | 152 +++++++++++++++
 tb/tb_multi_bit_serial_compare.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and result encodings for the chunked serial magnitude comparator.
package comparator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One-hot {l,e,g} result encodings
  localparam logic [2:0] L = 3'b100;
  localparam logic [2:0] E = 3'b010;
  localparam logic [2:0] G = 3'b001;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational unsigned compare of one chunk; flip_msb turns it into a
// two's-complement compare of the most-significant chunk.
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             flip_msb,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  logic [CHUNK-1:0] msk;
  logic [CHUNK-1:0] a_f;
  logic [CHUNK-1:0] b_f;

  always_comb begin
    msk          = '0;
    msk[CHUNK-1] = flip_msb;
    a_f          = a ^ msk;
    b_f          = b ^ msk;
    lt           = (a_f < b_f);
    eq           = (a_f == b_f);
    gt           = (a_f > b_f);
  end

endmodule

// File: rtl/multi_bit_serial_compare.sv
// Serial magnitude comparator: walks the operands CHUNK bits per clock, MSB
// chunk first, and stops at the first differing chunk or a cascade override.
module multi_bit_serial_compare
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             lin,
  input  logic             gin,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             smode_q, smode_d;
  logic             lin_q, lin_d, gin_q, gin_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [2:0]       res_q, res_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic             c_lt, c_eq, c_gt;
  logic             decide;
  logic [2:0]       res_next;

  // Shift the current chunk up to the top so a constant part-select picks it
  always_comb begin
    a_sh = a_q << (int'(idx_q) * CHUNK);
    b_sh = b_q << (int'(idx_q) * CHUNK);
  end

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .a        (a_sh[WIDTH-1 -: CHUNK]),
    .b        (b_sh[WIDTH-1 -: CHUNK]),
    .flip_msb (smode_q && (idx_q == '0)),
    .lt       (c_lt),
    .eq       (c_eq),
    .gt       (c_gt)
  );

  // lin outranks gin; both short-circuit the operand compare
  always_comb begin
    decide   = 1'b0;
    res_next = E;
    if (lin_q) begin
      decide   = 1'b1;
      res_next = L;
    end else if (gin_q) begin
      decide   = 1'b1;
      res_next = G;
    end else if (c_lt) begin
      decide   = 1'b1;
      res_next = L;
    end else if (c_gt) begin
      decide   = 1'b1;
      res_next = G;
    end else if (c_eq && (idx_q == LAST_IDX)) begin
      decide   = 1'b1;
      res_next = E;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      smode_q <= 1'b0;
      lin_q   <= 1'b0;
      gin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      smode_q <= smode_d;
      lin_q   <= lin_d;
      gin_q   <= gin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = RUN;
      RUN:     if (decide) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and latches; done is a single-cycle pulse
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    smode_d = smode_q;
    lin_d   = lin_q;
    gin_d   = gin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
    if (state_q == IDLE) begin
      if (start) begin
        idx_d   = '0;
        a_d     = a;
        b_d     = b;
        smode_d = signed_mode;
        lin_d   = lin;
        gin_d   = gin;
        busy_d  = 1'b1;
        res_d   = '0;
      end
    end else if (decide) begin
      res_d  = res_next;
      done_d = 1'b1;
      busy_d = 1'b0;
    end else begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign {l, e, g} = res_q;

endmodule

// File: tb/tb_multi_bit_serial_compare.sv
// Self-checking bench for multi_bit_serial_compare at WIDTH=8, CHUNK=2.
module tb_multi_bit_serial_compare;

  localparam int WIDTH = 8;
  localparam int CHUNK = 2;
  localparam logic [2:0] RL = 3'b100;
  localparam logic [2:0] RE = 3'b010;
  localparam logic [2:0] RG = 3'b001;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             signed_mode, lin, gin;
  logic             busy, done, l, e, g;

  multi_bit_serial_compare #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .lin         (lin),
    .gin         (gin),
    .busy        (busy),
    .done        (done),
    .l           (l),
    .e           (e),
    .g           (g)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sm;
    logic             lin;
    logic             gin;
    logic [2:0]       res;
    int               lat;
  } vec_t;

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a request at the falling edge; it is accepted at the next rising edge.
  task automatic do_start(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vsm, input logic vlin, input logic vgin,
                          input logic [2:0] eres, input int elat);
    exp_t x;
    @(negedge clk);
    a = va; b = vb; signed_mode = vsm; lin = vlin; gin = vgin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x.res = eres; x.lat = elat; x.acc = cyc;
    sb.push_back(x);
  endtask

  task automatic wait_done(input string name);
    exp_t x;
    int   n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      check({name, "_busy"}, int'(busy), 1);
      @(posedge clk);
      #1;
      n++;
    end
    if (done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done after %0d cycles", name, n);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_unexpected_done: done with empty scoreboard", name);
    end else begin
      x = sb.pop_front();
      check({name, "_res"}, int'({l, e, g}), int'(x.res));
      check({name, "_lat"}, cyc - x.acc, x.lat);
      check({name, "_busy_low"}, int'(busy), 0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, RE, 4};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, RG, 1};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, RL, 1};
    vecs[3] = '{8'h12, 8'h13, 1'b0, 1'b0, 1'b0, RL, 4};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, RL, 1};
    vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, RG, 1};
    vecs[6] = '{8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, RL, 1};
    vecs[7] = '{8'h7F, 8'h7E, 1'b1, 1'b0, 1'b0, RG, 4};
    vecs[8] = '{8'h34, 8'h38, 1'b0, 1'b0, 1'b0, RL, 3};
    vecs[9] = '{8'h80, 8'h80, 1'b1, 1'b0, 1'b0, RE, 4};

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; lin = 1'b0; gin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state", int'({busy, done, l, e, g}), 0);

    for (int i = 0; i < 10; i++) begin
      do_start(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].lin, vecs[i].gin,
               vecs[i].res, vecs[i].lat);
      wait_done($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), int'(done), 0);
      check($sformatf("vec%0d_hold", i), int'({l, e, g}), int'(vecs[i].res));
    end

    // A second start while busy must be dropped, not queued.
    do_start(8'h12, 8'h13, 1'b0, 1'b0, 1'b0, RL, 4);
    @(posedge clk);
    #1;
    @(negedge clk);
    a = 8'hFF; b = 8'h00; lin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; lin = 1'b0;
    wait_done("ignored_start");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("ignored_start_no_requeue", int'(done), 0);
    end

    // Asynchronous reset in the middle of a compare.
    do_start(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, RE, 4);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_reset_outputs", int'({busy, done, l, e, g}), 0);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("mid_reset_no_done", int'({busy, done}), 0);
    end

    // Back-to-back: second start issued in the done cycle.
    do_start(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, RG, 1);
    wait_done("b2b_first");
    do_start(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, RL, 4);
    check("b2b_clear_done", int'(done), 0);
    check("b2b_clear_res", int'({l, e, g}), 0);
    wait_done("b2b_second");

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
